pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencing controller for the two-stage (fetch/decode/execute -> memory/writeback) processor pipeline.
//  Drives PC write enable, the stage-split register enable and bubble insertion.
//  Selects ALU-result forwarding, stalls on load-use, squashes wrong-path slots after a branch/jal redirect,
//  and freezes the pipe on slow data-memory/IO accesses. Also keeps cycle/stall/flush performance counters.
// PARAMETERS
//  REG_INDEX_BIT_WIDTH  4   register index width
//  FLUSH_CYCLES         1   wrong-path slots squashed after a redirect (0..15; 0 = no squash)
//  MEM_TIMEOUT          64  max MEM_WAIT cycles before forced release (>=1)
//  CNT_BITS             32  width of each performance counter
// PORTS
//  clk          in   1   processor clock
//  reset        in   1   asynchronous, active-low reset
//  s1_sr1       in   RIW source register 1 of the stage-1 instruction
//  s1_sr2       in   RIW source register 2 of the stage-1 instruction
//  s1_use1      in   1   stage-1 reads sr1
//  s1_use2      in   1   stage-1 reads sr2
//  s1_redirect  in   1   stage-1 branch taken or jal (PC mux not selecting PC+4)
//  m_valid      in   1   memory stage holds a real (non-bubble) instruction
//  m_regWrite   in   1   memory-stage instruction writes a register
//  m_memtoReg   in   1   memory-stage instruction is a load
//  m_dr         in   RIW destination register of the memory-stage instruction
//  m_memAccess  in   1   memory-stage instruction reads or writes data memory/IO
//  mem_ready    in   1   data memory/IO completes the access this cycle
//  pcWrtEn      out  1   PC register write enable
//  pipeEn       out  1   stage-split register write enable
//  bubble       out  1   stage-split captures a NOP (clears valid/regWrite/memWrite)
//  fwd1         out  1   stage-1 operand 1 takes the memory-stage ALU result
//  fwd2         out  1   stage-1 operand 2 takes the memory-stage ALU result
//  mem_err      out  1   sticky: a MEM_WAIT timeout has occurred
//  cycle_cnt    out  CNT_BITS  cycles since reset
//  stall_cnt    out  CNT_BITS  cycles with pcWrtEn=0
//  flush_cnt    out  CNT_BITS  slots squashed
// BEHAVIOUR
//  Reset (async, reset==0): state=RUN; all counters 0; flush counter 0; mem_err=0.
//   Outputs during reset: pcWrtEn=1, pipeEn=1, bubble=1, fwd1=fwd2=0.
//  Hazard terms, combinational on inputs:
//   hit1 = m_valid & m_regWrite & s1_use1 & (m_dr==s1_sr1)
//   hit2 = m_valid & m_regWrite & s1_use2 & (m_dr==s1_sr2)
//   fwdN = hitN & ~m_memtoReg
//   loaduse = (hit1|hit2) & m_memtoReg
//   memstall = m_valid & m_memAccess & ~mem_ready
//  States: RUN, FLUSH, MEM_WAIT. Priority per cycle: memstall > squash > loaduse > redirect.
//  RUN:
//   - memstall: pcWrtEn=0, pipeEn=0; go MEM_WAIT; wait counter := 1.
//   - else loaduse: pcWrtEn=0, pipeEn=1, bubble=1. Single-cycle stall; the next cycle re-evaluates
//     with the bubble in the memory stage.
//   - else redirect with FLUSH_CYCLES>0: advance normally; go FLUSH; flush counter := FLUSH_CYCLES.
//   - else: pcWrtEn=1, pipeEn=1, bubble=0.
//  FLUSH:
//   - Stage-1 instruction is wrong-path. pcWrtEn=1, pipeEn=1, bubble=1, fwd=0.
//   - s1_redirect and loaduse are ignored. flush_cnt += 1; flush counter -= 1.
//   - Return to RUN when the counter reaches 0.
//   - memstall takes priority: freeze in MEM_WAIT, then resume FLUSH with the remaining count.
//  MEM_WAIT:
//   - pcWrtEn=0, pipeEn=0, fwd held off.
//   - On mem_ready: the registers advance this cycle, as in RUN/FLUSH; return to the saved state.
//   - If the wait counter reaches MEM_TIMEOUT without mem_ready: set mem_err, force release the
//     same way, and count the access as done.
//  Counters:
//   - cycle_cnt increments every cycle out of reset.
//   - stall_cnt increments when pcWrtEn=0.
//   - All counters wrap modulo 2^CNT_BITS.
//  Register 0 is not special: m_dr==0 matches like any other index.
//  Reset asserted mid-stall or mid-flush returns to RUN immediately; no partial state survives.
// TESTING
//  1. Forwarding: M=add r3 (regWrite, non-load), S1 reads r3 as sr2 -> fwd2=1, fwd1=0, no stall, stall_cnt unchanged.
//  2. Load-use: M=lw r5, S1 reads r5 as sr1 -> 1 cycle pcWrtEn=0, bubble=1; next cycle fwd1=0, pcWrtEn=1; stall_cnt=1.
//  3. Redirect, FLUSH_CYCLES=2: s1_redirect=1 -> next 2 cycles bubble=1; flush_cnt=2; back to RUN on cycle 3.
//  4. Memory wait: m_memAccess=1, mem_ready low for 3 cycles -> pcWrtEn=pipeEn=0 for 3 cycles, advance on the 4th; mem_err=0.
//  5. Timeout, MEM_TIMEOUT=4: mem_ready stuck low -> release after 4 cycles; mem_err=1 and stays 1 until reset.
//  6. Reset low mid-FLUSH -> state RUN, all counters 0, bubble=1 while low; first cycle after release: normal fetch.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a two-stage pipeline: forwarding, load-use stall,
// wrong-path squash after redirects, memory-wait freeze with timeout, and performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int FLUSH_CYCLES        = 1,
    parameter int MEM_TIMEOUT         = 64,
    parameter int CNT_BITS            = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] s1_sr1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] s1_sr2,
    input  logic                           s1_use1,
    input  logic                           s1_use2,
    input  logic                           s1_redirect,
    input  logic                           m_valid,
    input  logic                           m_regWrite,
    input  logic                           m_memtoReg,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] m_dr,
    input  logic                           m_memAccess,
    input  logic                           mem_ready,
    output logic                           pcWrtEn,
    output logic                           pipeEn,
    output logic                           bubble,
    output logic                           fwd1,
    output logic                           fwd2,
    output logic                           mem_err,
    output logic [CNT_BITS-1:0]            cycle_cnt,
    output logic [CNT_BITS-1:0]            stall_cnt,
    output logic [CNT_BITS-1:0]            flush_cnt
);
    localparam int WAIT_BITS = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_MEM_WAIT} state_t;

    state_t                 state_reg, state_next;
    state_t                 saved_reg, saved_next;
    logic [3:0]             flush_left_reg, flush_left_next;
    logic [WAIT_BITS-1:0]   wait_reg, wait_next;
    logic                   mem_err_reg;
    logic [CNT_BITS-1:0]    cycle_reg, stall_reg, flush_reg;

    logic [REG_INDEX_BIT_WIDTH-1:0] src [2];
    logic [1:0]             src_use, hit, fwd_raw;
    logic                   loaduse, memstall;
    logic                   in_wait, timeout, hold;
    state_t                 eff_state;
    logic                   pc_en, pipe_en, bub, fwd_en, squash, err_set;

    assign src[0]  = s1_sr1;
    assign src[1]  = s1_sr2;
    assign src_use = {s1_use2, s1_use1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit
            assign hit[gi]     = m_valid & m_regWrite & src_use[gi] & (m_dr == src[gi]);
            assign fwd_raw[gi] = hit[gi] & ~m_memtoReg;
        end
    endgenerate

    assign loaduse  = (|hit) & m_memtoReg;
    assign memstall = m_valid & m_memAccess & ~mem_ready;

    // While frozen only mem_ready or the timeout can release; the release cycle then
    // behaves exactly like the state that was interrupted.
    assign in_wait   = (state_reg == ST_MEM_WAIT);
    assign timeout   = in_wait & ~mem_ready & (wait_reg == WAIT_BITS'(MEM_TIMEOUT));
    assign hold      = in_wait ? (~mem_ready & ~timeout) : memstall;
    assign eff_state = in_wait ? saved_reg : state_reg;

    always_comb begin
        state_next      = state_reg;
        saved_next      = saved_reg;
        flush_left_next = flush_left_reg;
        wait_next       = wait_reg;
        pc_en           = 1'b1;
        pipe_en         = 1'b1;
        bub             = 1'b0;
        fwd_en          = 1'b0;
        squash          = 1'b0;
        err_set         = 1'b0;
        if (hold) begin
            pc_en   = 1'b0;
            pipe_en = 1'b0;
            if (!in_wait) begin
                state_next = ST_MEM_WAIT;
                saved_next = state_reg;
                wait_next  = WAIT_BITS'(1);
            end else begin
                wait_next  = wait_reg + 1'b1;
            end
        end else begin
            err_set    = timeout;
            state_next = eff_state;
            if (eff_state == ST_FLUSH) begin
                bub             = 1'b1;
                squash          = 1'b1;
                flush_left_next = flush_left_reg - 4'd1;
                if (flush_left_reg == 4'd1)
                    state_next = ST_RUN;
            end else if (loaduse) begin
                pc_en = 1'b0;
                bub   = 1'b1;
            end else begin
                fwd_en = 1'b1;
                if (s1_redirect && FLUSH_CYCLES > 0) begin
                    state_next      = ST_FLUSH;
                    flush_left_next = 4'(FLUSH_CYCLES);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_RUN;
            saved_reg      <= ST_RUN;
            flush_left_reg <= '0;
            wait_reg       <= '0;
            mem_err_reg    <= 1'b0;
            cycle_reg      <= '0;
            stall_reg      <= '0;
            flush_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            saved_reg      <= saved_next;
            flush_left_reg <= flush_left_next;
            wait_reg       <= wait_next;
            mem_err_reg    <= mem_err_reg | err_set;
            cycle_reg      <= cycle_reg + 1'b1;
            if (!pc_en)
                stall_reg <= stall_reg + 1'b1;
            if (squash)
                flush_reg <= flush_reg + 1'b1;
        end
    end

    // Reset forces a bubble into the stage split while the PC keeps loading its reset vector.
    assign pcWrtEn   = pc_en | ~reset;
    assign pipeEn    = pipe_en | ~reset;
    assign bubble    = bub | ~reset;
    assign fwd1      = fwd_raw[0] & fwd_en & reset;
    assign fwd2      = fwd_raw[1] & fwd_en & reset;
    assign mem_err   = mem_err_reg;
    assign cycle_cnt = cycle_reg;
    assign stall_cnt = stall_reg;
    assign flush_cnt = flush_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random
// traffic, each cycle's expectation produced by a behavioural model and checked by a monitor.
module tb_pipeline_hazard_ctrl;
    localparam int RIW = 4;
    localparam int FC  = 2;
    localparam int TMO = 4;
    localparam int CB  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [RIW-1:0] s1_sr1, s1_sr2, m_dr;
    logic           s1_use1, s1_use2, s1_redirect;
    logic           m_valid, m_regWrite, m_memtoReg, m_memAccess, mem_ready;
    logic           pcWrtEn, pipeEn, bubble, fwd1, fwd2, mem_err;
    logic [CB-1:0]  cycle_cnt, stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(
        .REG_INDEX_BIT_WIDTH(RIW),
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT(TMO),
        .CNT_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset),
        .s1_sr1(s1_sr1), .s1_sr2(s1_sr2), .s1_use1(s1_use1), .s1_use2(s1_use2),
        .s1_redirect(s1_redirect),
        .m_valid(m_valid), .m_regWrite(m_regWrite), .m_memtoReg(m_memtoReg),
        .m_dr(m_dr), .m_memAccess(m_memAccess), .mem_ready(mem_ready),
        .pcWrtEn(pcWrtEn), .pipeEn(pipeEn), .bubble(bubble),
        .fwd1(fwd1), .fwd2(fwd2), .mem_err(mem_err),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic           rst;
        logic [RIW-1:0] sr1, sr2, dr;
        logic           use1, use2, redir, mv, mrw, mload, macc, mrdy;
    } stim_t;

    typedef struct packed {
        logic          pc, pipe, bub, f1, f2, err;
        logic [CB-1:0] cyc, stl, fl;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_seen  = 0;

    // Model: pending wait length, remaining wrong-path slots, sticky error, counters.
    logic          md_wait;
    int            md_waited;
    int            md_sq;
    logic          md_err;
    logic [CB-1:0] md_cyc, md_stl, md_fl;

    task automatic model_clear();
        md_wait = 1'b0; md_waited = 0; md_sq = 0; md_err = 1'b0;
        md_cyc = '0; md_stl = '0; md_fl = '0;
    endtask

    task automatic model_step(input stim_t s, output exp_t e);
        logic h1, h2, ld, hold;
        e = '0;
        if (!s.rst) begin
            model_clear();
            e.pc = 1'b1; e.pipe = 1'b1; e.bub = 1'b1;
        end else begin
            e.err = md_err; e.cyc = md_cyc; e.stl = md_stl; e.fl = md_fl;
            h1 = s.mv && s.mrw && s.use1 && (s.dr == s.sr1);
            h2 = s.mv && s.mrw && s.use2 && (s.dr == s.sr2);
            ld = (h1 || h2) && s.mload;
            if (md_wait) hold = !s.mrdy && (md_waited < TMO);
            else         hold = s.mv && s.macc && !s.mrdy;
            if (hold) begin
                md_waited = md_wait ? md_waited + 1 : 1;
                md_wait   = 1'b1;
            end else begin
                if (md_wait && !s.mrdy) md_err = 1'b1;
                md_wait = 1'b0;
                e.pipe  = 1'b1;
                if (md_sq > 0) begin
                    e.pc = 1'b1; e.bub = 1'b1;
                    md_sq = md_sq - 1;
                    md_fl = md_fl + 1;
                end else if (ld) begin
                    e.bub = 1'b1;
                end else begin
                    e.pc = 1'b1;
                    e.f1 = h1 && !s.mload;
                    e.f2 = h2 && !s.mload;
                    if (s.redir && FC > 0) md_sq = FC;
                end
            end
            if (!e.pc) md_stl = md_stl + 1;
            md_cyc = md_cyc + 1;
        end
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        reset = s.rst;
        s1_sr1 = s.sr1; s1_sr2 = s.sr2; s1_use1 = s.use1; s1_use2 = s.use2;
        s1_redirect = s.redir;
        m_valid = s.mv; m_regWrite = s.mrw; m_memtoReg = s.mload; m_dr = s.dr;
        m_memAccess = s.macc; mem_ready = s.mrdy;
        model_step(s, e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [CB-1:0] act, input logic [CB-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, n_seen, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_seen++;
                chk("pcWrtEn",   {31'b0, pcWrtEn}, {31'b0, e.pc});
                chk("pipeEn",    {31'b0, pipeEn},  {31'b0, e.pipe});
                chk("bubble",    {31'b0, bubble},  {31'b0, e.bub});
                chk("fwd1",      {31'b0, fwd1},    {31'b0, e.f1});
                chk("fwd2",      {31'b0, fwd2},    {31'b0, e.f2});
                chk("mem_err",   {31'b0, mem_err}, {31'b0, e.err});
                chk("cycle_cnt", cycle_cnt, e.cyc);
                chk("stall_cnt", stall_cnt, e.stl);
                chk("flush_cnt", flush_cnt, e.fl);
                $display("[TB] cyc %0d pc=%b pipe=%b bub=%b fwd=%b%b err=%b cnt=%0d/%0d/%0d",
                         n_seen, pcWrtEn, pipeEn, bubble, fwd1, fwd2, mem_err,
                         cycle_cnt, stall_cnt, flush_cnt);
            end
        end
    end

    initial begin : driver
        stim_t idle, s;
        int    low_run;
        reset = 1'b0;
        s1_sr1 = '0; s1_sr2 = '0; m_dr = '0;
        s1_use1 = 1'b0; s1_use2 = 1'b0; s1_redirect = 1'b0;
        m_valid = 1'b0; m_regWrite = 1'b0; m_memtoReg = 1'b0;
        m_memAccess = 1'b0; mem_ready = 1'b1;
        model_clear();

        idle = '0; idle.rst = 1'b1; idle.mrdy = 1'b1;
        s = idle; s.rst = 1'b0;
        apply(s); apply(s);
        apply(idle); apply(idle);

        // ALU result forwarded to operand 2
        s = idle; s.mv = 1; s.mrw = 1; s.dr = 4'd3; s.sr2 = 4'd3; s.use2 = 1; s.sr1 = 4'd1; s.use1 = 1;
        apply(s);
        // load-use: one stall, then the bubble sits in the memory stage
        s = idle; s.mv = 1; s.mrw = 1; s.mload = 1; s.dr = 4'd5; s.sr1 = 4'd5; s.use1 = 1;
        apply(s);
        s.mv = 0;
        apply(s);
        apply(idle);
        // redirect with redirects ignored during the squash slots
        s = idle; s.redir = 1;
        apply(s); apply(s); apply(s);
        apply(idle); apply(idle);
        // memory wait of three cycles
        s = idle; s.mv = 1; s.macc = 1; s.mrdy = 0;
        repeat (3) apply(s);
        s.mrdy = 1;
        apply(s);
        apply(idle);
        // stuck memory: forced release and sticky error
        s.mrdy = 0;
        repeat (5) apply(s);
        apply(idle); apply(idle);
        // register 0 matches like any other index
        s = idle; s.mv = 1; s.mrw = 1; s.dr = 4'd0; s.sr1 = 4'd0; s.use1 = 1;
        apply(s);
        // reset in the middle of a squash
        s = idle; s.redir = 1;
        apply(s);
        s = idle; s.rst = 0;
        apply(s); apply(s);
        apply(idle); apply(idle);

        low_run = 0;
        for (int i = 0; i < 600; i++) begin
            s = '0;
            s.rst   = ($urandom_range(0, 149) != 0);
            s.sr1   = 4'($urandom_range(0, 3));
            s.sr2   = 4'($urandom_range(0, 3));
            s.dr    = 4'($urandom_range(0, 3));
            s.use1  = 1'($urandom_range(0, 1));
            s.use2  = 1'($urandom_range(0, 1));
            s.redir = ($urandom_range(0, 5) == 0);
            s.mv    = ($urandom_range(0, 3) != 0);
            s.mrw   = ($urandom_range(0, 3) != 0);
            s.mload = ($urandom_range(0, 2) == 0);
            s.macc  = ($urandom_range(0, 2) == 0);
            if (low_run > 0) begin
                s.mrdy  = 1'b0;
                low_run = low_run - 1;
            end else begin
                s.mrdy = 1'b1;
                if ($urandom_range(0, 7) == 0) low_run = $urandom_range(1, 6);
            end
            apply(s);
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
